// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Constants and types shared by the synth oscillator and the
//                pitch detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

  // Divider width shared by the note oscillator and the pitch detector.
  localparam int PD_WIDTH = 18;

  // Pitch detector measurement states.
  typedef enum logic [1:0] {
    PD_IDLE    = 2'd0,
    PD_ARM     = 2'd1,
    PD_MEASURE = 2'd2
  } pd_state_t;

endpackage
`default_nettype wire

// File: rtl/pitch_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : pitch_detector_if
//  Description : Control and result bundle of the pitch detector.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pitch_detector_if #(
  parameter int WIDTH = 18
);
  logic             enable;
  logic             sig_in;
  logic [1:0]       octve_dwn;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] divider;
  logic             valid;
  logic             locked;
  logic             timeout;

  // Consumer side: drives control, observes results.
  modport master (
    output enable, sig_in, octve_dwn,
    input  period, divider, valid, locked, timeout
  );

  // Detector side.
  modport slave (
    input  enable, sig_in, octve_dwn,
    output period, divider, valid, locked, timeout
  );
endinterface
`default_nettype wire

// File: rtl/pitch_detector_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : edge_sync
//  Description : Multi-flop synchronizer followed by a registered rising-edge
//                detector. Latency from input rise to rise pulse is
//                SYNC_STAGES+1 clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic nRst,
  input  wire logic sig_in,
  output logic      rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  // Synchronizer chain, previous-value flop and registered edge pulse.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/pitch_detector.sv
`default_nettype none
// ============================================================================
//  Module      : pitch_detector
//  Description : Measures the period of a square wave in clk cycles, averages
//                2^AVG_LOG2 periods and recovers the oscillator divider with
//                the octave shift removed. Reports lock and timeout status.
//  Revision    : 1.0 - initial release
// ============================================================================
module pitch_detector
  import synth_pkg::*;
#(
  parameter int WIDTH       = PD_WIDTH,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 4
) (
  input wire logic        clk,
  input wire logic        nRst,
  pitch_detector_if.slave bus
);

  localparam logic [1:0]          c_idle    = PD_IDLE;
  localparam logic [1:0]          c_arm     = PD_ARM;
  localparam logic [1:0]          c_measure = PD_MEASURE;
  localparam int                  c_aw      = WIDTH + AVG_LOG2;
  localparam logic [WIDTH-1:0]    c_cnt_max = '1;
  localparam logic [WIDTH-1:0]    c_min     = WIDTH'(MIN_PERIOD);
  localparam logic [AVG_LOG2:0]   c_last    = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_count;
  logic [c_aw-1:0]   r_acc;
  logic [AVG_LOG2:0] r_nsamp;
  logic [WIDTH-1:0]  r_period;
  logic [WIDTH-1:0]  r_divider;
  logic              r_valid;
  logic              r_locked;
  logic              r_timeout;

  logic              w_rise;
  logic              w_sat;
  logic              w_accept;
  logic [c_aw-1:0]   w_sum;
  logic [WIDTH-1:0]  w_avg;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk    (clk),
    .nRst   (nRst),
    .sig_in (bus.sig_in),
    .rise   (w_rise)
  );

  // Counter value at a rise is the sample; saturation only matters while
  // armed or measuring.
  assign w_sat    = (r_state != c_idle) && (r_count == c_cnt_max);
  assign w_accept = w_rise && (r_count >= c_min);
  assign w_sum    = r_acc + c_aw'(r_count);
  assign w_avg    = WIDTH'(w_sum >> AVG_LOG2);

  // Measurement FSM, period counter, accumulator and result registers.
  // Priority: disable, then saturation, then edge handling.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= c_idle;
      r_count   <= '0;
      r_acc     <= '0;
      r_nsamp   <= '0;
      r_period  <= '0;
      r_divider <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      if (!bus.enable) begin
        r_state   <= c_idle;
        r_count   <= '0;
        r_acc     <= '0;
        r_nsamp   <= '0;
        r_period  <= '0;
        r_divider <= '0;
        r_locked  <= 1'b0;
      end else if (r_state == c_idle) begin
        r_state <= c_arm;
        r_count <= '0;
      end else if (w_sat) begin
        // Lost the signal: keep the last result, drop lock, re-arm.
        r_timeout <= 1'b1;
        r_locked  <= 1'b0;
        r_acc     <= '0;
        r_nsamp   <= '0;
        r_count   <= '0;
        r_state   <= c_arm;
      end else if (r_state == c_arm) begin
        if (w_rise) begin
          // Loading 1 makes the counter equal the edge spacing at the next rise.
          r_count <= WIDTH'(1);
          r_state <= c_measure;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else if (r_state == c_measure) begin
        if (w_accept) begin
          r_count <= WIDTH'(1);
          if (r_nsamp == c_last) begin
            r_period  <= w_avg;
            r_divider <= w_avg >> bus.octve_dwn;
            r_valid   <= 1'b1;
            r_locked  <= 1'b1;
            r_acc     <= '0;
            r_nsamp   <= '0;
          end else begin
            r_acc   <= w_sum;
            r_nsamp <= r_nsamp + 1'b1;
          end
        end else begin
          // Glitch edges are ignored and do not restart the counter.
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_state <= c_idle;
      end
    end
  end

  assign bus.period  = r_period;
  assign bus.divider = r_divider;
  assign bus.valid   = r_valid;
  assign bus.locked  = r_locked;
  assign bus.timeout = r_timeout;

endmodule
`default_nettype wire
